// File: rtl/conv_layer_output_interface.sv
// rtl/conv_layer_output_interface.sv - captures kernel-array feature rows and serializes them onto an addressed word stream
module conv_layer_output_interface #(
    parameter int WIDTH      = 32,
    parameter int ARRAY_SIZE = 6,
    parameter int OUT_ROWS   = 6,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    cmd,
    output logic [1:0]                    ack,
    input  logic [ARRAY_SIZE*WIDTH-1:0]   feature_in,
    input  logic                          feature_valid,
    output logic                          feature_ready,
    output logic [WIDTH-1:0]              o_data,
    output logic                          o_valid,
    input  logic                          o_ready,
    output logic [ADDR_WIDTH-1:0]         o_addr,
    output logic [2:0]                    current_state
);

    localparam int LW = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1;
    localparam int RW = $clog2(OUT_ROWS + 1);

    localparam logic [1:0] CMD_START = 2'b01;
    localparam logic [1:0] CMD_ABORT = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_ROW = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_DONE     = 3'd3
    } state_t;

    state_t                        r_state;
    state_t                        w_next_state;
    logic [ARRAY_SIZE*WIDTH-1:0]   r_row_buf;
    logic [LW-1:0]                 r_lane_cnt;
    logic [RW-1:0]                 r_row_cnt;
    logic [ADDR_WIDTH-1:0]         r_addr;

    logic                          w_abort;
    logic                          w_start;
    logic                          w_last_lane;
    logic                          w_last_row;
    logic                          w_xfer;
    logic [WIDTH-1:0]              w_lanes [ARRAY_SIZE];

    assign w_abort     = (cmd == CMD_ABORT);
    assign w_start     = (cmd == CMD_START);
    assign w_last_lane = (r_lane_cnt == LW'(ARRAY_SIZE - 1));
    assign w_last_row  = (r_row_cnt == RW'(OUT_ROWS - 1));
    // Abort wins over a handshake in the same cycle, so the word is dropped
    assign w_xfer      = (r_state == ST_DRAIN) && o_ready && !w_abort;

    // Lane 0 sits in the most significant slice of the captured row
    for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
        assign w_lanes[g] = r_row_buf[(ARRAY_SIZE-1-g)*WIDTH +: WIDTH];
    end

    assign o_data        = w_lanes[r_lane_cnt];
    assign o_addr        = r_addr;
    assign o_valid       = (r_state == ST_DRAIN);
    assign feature_ready = (r_state == ST_WAIT_ROW);
    assign current_state = r_state;

    // State register
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and ack decode
    always_comb begin
        w_next_state = r_state;
        ack          = 2'b00;
        case (r_state)
            ST_IDLE: begin
                ack = 2'b00;
                if (w_start) w_next_state = ST_WAIT_ROW;
            end
            ST_WAIT_ROW: begin
                ack = 2'b01;
                if (feature_valid) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                ack = 2'b01;
                if (o_ready && w_last_lane) begin
                    w_next_state = w_last_row ? ST_DONE : ST_WAIT_ROW;
                end
            end
            ST_DONE: begin
                ack = 2'b10;
                if (w_start) w_next_state = ST_WAIT_ROW;
            end
            default: begin
                ack          = 2'b00;
                w_next_state = ST_IDLE;
            end
        endcase
        if (w_abort) w_next_state = ST_IDLE;
    end

    // Row buffer, lane/row counters and frame address
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_row_buf  <= '0;
            r_lane_cnt <= '0;
            r_row_cnt  <= '0;
            r_addr     <= '0;
        end else if (w_abort) begin
            r_lane_cnt <= '0;
            r_row_cnt  <= '0;
            r_addr     <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (w_start) begin
                        r_lane_cnt <= '0;
                        r_row_cnt  <= '0;
                        r_addr     <= '0;
                    end
                end
                ST_WAIT_ROW: begin
                    if (feature_valid) begin
                        r_row_buf  <= feature_in;
                        r_lane_cnt <= '0;
                    end
                end
                ST_DRAIN: begin
                    if (w_xfer) begin
                        r_addr <= r_addr + 1'b1;
                        if (w_last_lane) begin
                            r_lane_cnt <= '0;
                            r_row_cnt  <= r_row_cnt + 1'b1;
                        end else begin
                            r_lane_cnt <= r_lane_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_lane_cnt <= '0;
                    r_row_cnt  <= '0;
                    r_addr     <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_layer_output_interface.sv
// tb/tb_conv_layer_output_interface.sv - self-checking bench for conv_layer_output_interface
module tb_conv_layer_output_interface;

    localparam int W  = 32;
    localparam int N  = 6;
    localparam int R  = 6;
    localparam int AW = 6;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [1:0]      cmd = 2'b00;
    logic [1:0]      ack;
    logic [N*W-1:0]  feature_in = '0;
    logic            feature_valid = 1'b0;
    logic            feature_ready;
    logic [W-1:0]    o_data;
    logic            o_valid;
    logic            o_ready = 1'b0;
    logic [AW-1:0]   o_addr;
    logic [2:0]      current_state;

    int checks = 0;
    int errors = 0;

    // Expected word stream: {address, data}, pushed on capture, popped on transfer
    logic [AW+W-1:0] exp_q[$];

    conv_layer_output_interface #(
        .WIDTH(W), .ARRAY_SIZE(N), .OUT_ROWS(R), .ADDR_WIDTH(AW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .ack(ack),
        .feature_in(feature_in), .feature_valid(feature_valid), .feature_ready(feature_ready),
        .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready), .o_addr(o_addr),
        .current_state(current_state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // IEEE-754 single encoding of a small positive integer
    function automatic logic [31:0] flt(input int n);
        int e;
        e = 0;
        while ((n >> (e + 1)) != 0) e++;
        return {1'b0, 8'(127 + e), 23'((n - (1 << e)) << (23 - e))};
    endfunction

    task automatic run_frame(input int ready_mode, input bit use_float, input bit junk,
                             input int abort_addr, input int reset_row);
        logic [W-1:0]    row [N];
        logic [AW+W-1:0] e;
        int              k;
        int              stall;
        bit              rd;
        @(negedge clk);
        cmd = 2'b01; feature_valid = 1'b0; o_ready = 1'b0;
        @(negedge clk);
        cmd = 2'b00;
        chk("start_state", current_state, 3'd1);
        chk("start_ack", ack, 2'b01);
        chk("start_addr", o_addr, 0);
        k = 0;
        stall = 0;
        for (int r = 0; r < R; r++) begin
            chk("wait_ready", feature_ready, 1'b1);
            chk("wait_valid", o_valid, 1'b0);
            for (int l = 0; l < N; l++) begin
                row[l] = use_float ? flt(r * N + l + 1) : $urandom;
                feature_in[(N-1-l)*W +: W] = row[l];
                exp_q.push_back({AW'(r * N + l), row[l]});
            end
            feature_valid = 1'b1;
            @(negedge clk);
            feature_valid = 1'b0;
            chk("first_valid", o_valid, 1'b1);
            if (r == reset_row) begin
                #2 rst_n = 1'b1;
                #1;
                chk("rst_mid_state", current_state, 3'd0);
                chk("rst_mid_valid", o_valid, 1'b0);
                chk("rst_mid_ready", feature_ready, 1'b0);
                chk("rst_mid_ack", ack, 2'b00);
                chk("rst_mid_addr", o_addr, 0);
                exp_q.delete();
                @(negedge clk);
                rst_n = 1'b0;
                return;
            end
            for (int l = 0; l < N; ) begin
                e = exp_q[0];
                chk("drain_valid", o_valid, 1'b1);
                chk("drain_fready", feature_ready, 1'b0);
                chk("drain_data", o_data, e[W-1:0]);
                chk("drain_addr", o_addr, e[AW+W-1:W]);
                chk("drain_ack", ack, 2'b01);
                if (abort_addr == int'(e[AW+W-1:W])) begin
                    cmd = 2'b11; o_ready = 1'b1;
                    @(negedge clk);
                    cmd = 2'b00; o_ready = 1'b0;
                    chk("abort_state", current_state, 3'd0);
                    chk("abort_valid", o_valid, 1'b0);
                    chk("abort_ack", ack, 2'b00);
                    chk("abort_addr", o_addr, 0);
                    exp_q.delete();
                    return;
                end
                case (ready_mode)
                    0:       rd = 1'b1;
                    1:       rd = (k % 3 == 0);
                    default: rd = ($urandom_range(0, 1) == 1) || (stall >= 3);
                endcase
                k++;
                stall = rd ? 0 : stall + 1;
                o_ready = rd;
                if (junk && $urandom_range(0, 1) == 1) begin
                    for (int j = 0; j < N; j++) feature_in[j*W +: W] = $urandom;
                    feature_valid = 1'b1;
                    cmd = 2'b01;
                end
                @(negedge clk);
                feature_valid = 1'b0; cmd = 2'b00; o_ready = 1'b0;
                if (rd) begin
                    void'(exp_q.pop_front());
                    l++;
                end
            end
        end
        chk("done_state", current_state, 3'd3);
        chk("done_ack", ack, 2'b10);
        chk("done_addr", o_addr, R * N);
        chk("done_valid", o_valid, 1'b0);
        chk("done_fready", feature_ready, 1'b0);
        chk("done_queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        #13 rst_n = 1'b1;
        #1;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_fready", feature_ready, 1'b0);
        chk("rst_ack", ack, 2'b00);
        chk("rst_addr", o_addr, 0);
        chk("rst_state", current_state, 3'd0);
        chk("rst_data", o_data, 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("idle_hold_state", current_state, 3'd0);
        chk("idle_hold_ack", ack, 2'b00);

        run_frame(0, 1'b1, 1'b0, -1, -1);
        run_frame(1, 1'b0, 1'b0, -1, -1);
        run_frame(2, 1'b0, 1'b1, -1, -1);
        run_frame(0, 1'b0, 1'b0, 14, -1);
        run_frame(0, 1'b1, 1'b0, -1, -1);
        run_frame(2, 1'b0, 1'b0, -1, 3);
        run_frame(2, 1'b1, 1'b1, -1, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
